// File: rtl/t64_seq_pkg.sv
// Shared definitions for the t64_seq bit-serial counter sequencer.
package t64_seq_pkg;

  localparam int AW = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INC  = 2'd1,
    ST_RD   = 2'd2,
    ST_CLR  = 2'd3
  } state_e;

  localparam logic OP_RD  = 1'b0;
  localparam logic OP_CLR = 1'b1;

endpackage

// File: rtl/t64_seq_rr_arb.sv
// N-way round-robin arbiter; the search starts just after the last granted
// requester and the pointer moves only when a grant is taken (en high).
module rr_arb #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          c,
  input  logic          rn,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic          gnt_v,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] last;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_v   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last) + k) % N);
      if (!gnt_v && req[cand]) begin
        gnt_v   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Reset to N-1 so the first search after reset begins at requester 0.
  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      last <= IW'(N - 1);
    end else if (en && gnt_v) begin
      last <= gnt_idx;
    end
  end

endmodule

// File: rtl/t64_seq.sv
// Bit-serial sequencer packing N W-bit counters into a 64x1 store.
// Optional per-counter wrap flags when T64_SEQ_OVF_EN is defined.
//
// Command handshake: cmd_go is a single-cycle strobe taken only while busy==0;
// a strobe seen while busy==1 is dropped (no queueing, no back-pressure).
module t64_seq
  import t64_seq_pkg::*;
#(
  parameter int W  = 8,
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          c,
  input  logic          rn,
  input  logic [N-1:0]  inc,
  input  logic          cmd_go,
  input  logic          cmd_op,
  input  logic [IW-1:0] cmd_idx,
  output logic          busy,
  output logic          rd_vld,
  output logic [W-1:0]  rd_data,
  output logic          lost,
  output logic [AW-1:0] mem_s,
  output logic          mem_ce,
  output logic          mem_r,
  output logic          mem_d,
  input  logic          mem_q,
`ifdef T64_SEQ_OVF_EN
  output logic [N-1:0]  ovf,
`endif
  output state_e        dbg_state
);

  if (N * W > 64 || W < 2) begin : g_size_chk
    $error("t64_seq: N*W must not exceed 64 and W must be at least 2");
  end

  state_e        state, state_n;
  logic [IW-1:0] g, g_n;
  logic [AW-1:0] bitc, bit_n;
  logic [N-1:0]  pend, pend_n;
  logic [N-1:0]  gnt_mask, clr_mask;
  logic          lost_n;
  logic          last_bit;
  logic          arb_en, gnt_v, cmd_ok;
  logic [IW-1:0] gnt_idx;
  logic [AW-1:0] addr;

  rr_arb #(.N(N), .IW(IW)) u_arb (
    .c       (c),
    .rn      (rn),
    .req     (pend),
    .en      (arb_en),
    .gnt_v   (gnt_v),
    .gnt_idx (gnt_idx)
  );

  assign dbg_state = state;
  assign last_bit  = (bitc == AW'(W - 1));
  assign addr      = AW'(g) * AW'(W) + bitc;
  // Out-of-range indices (non power-of-two N) are never accepted.
  assign cmd_ok    = cmd_go && (int'(cmd_idx) < N);

  always_comb begin
    state_n = state;
    g_n     = g;
    bit_n   = bitc;
    busy    = (state != ST_IDLE);
    arb_en  = 1'b0;
    mem_s   = '0;
    mem_ce  = 1'b0;
    mem_r   = 1'b0;
    mem_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        arb_en = !cmd_ok;
        if (cmd_ok) begin
          state_n = (cmd_op == OP_CLR) ? ST_CLR : ST_RD;
          g_n     = cmd_idx;
          bit_n   = '0;
        end else if (gnt_v) begin
          state_n = ST_INC;
          g_n     = gnt_idx;
          bit_n   = '0;
        end
      end
      // Carry is always 1 while rippling, so each bit simply flips; a 0 bit
      // absorbs the carry and ends the increment.
      ST_INC: begin
        mem_s  = addr;
        mem_ce = 1'b1;
        mem_d  = ~mem_q;
        bit_n  = bitc + AW'(1);
        if (!mem_q || last_bit) state_n = ST_IDLE;
      end
      ST_RD: begin
        mem_s = addr;
        bit_n = bitc + AW'(1);
        if (last_bit) state_n = ST_IDLE;
      end
      ST_CLR: begin
        mem_s = addr;
        mem_r = 1'b1;
        bit_n = bitc + AW'(1);
        if (last_bit) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_mask = '0;
    clr_mask = '0;
    if (arb_en && gnt_v) gnt_mask[gnt_idx] = 1'b1;
    if (state == ST_IDLE && cmd_ok && cmd_op == OP_CLR) clr_mask[cmd_idx] = 1'b1;
    // A pulse on the granted counter re-arms its request instead of being lost.
    pend_n = (pend & ~gnt_mask & ~clr_mask) | inc;
    lost_n = lost | (|(inc & pend & ~gnt_mask));
  end

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      state   <= ST_IDLE;
      g       <= '0;
      bitc    <= '0;
      pend    <= '0;
      lost    <= 1'b0;
      rd_vld  <= 1'b0;
      rd_data <= '0;
    end else begin
      state  <= state_n;
      g      <= g_n;
      bitc   <= bit_n;
      pend   <= pend_n;
      lost   <= lost_n;
      rd_vld <= (state == ST_RD) && last_bit;
      if (state == ST_RD) rd_data <= {mem_q, rd_data[W-1:1]};
    end
  end

`ifdef T64_SEQ_OVF_EN
  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      ovf <= '0;
    end else begin
      if (state == ST_INC && last_bit && mem_q) ovf[g] <= 1'b1;
      if (state == ST_IDLE && cmd_ok && cmd_op == OP_CLR) ovf[cmd_idx] <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_t64_seq.sv
// Self-checking bench for t64_seq: behavioural 64x1 store plus a counter-level
// reference model (values, round-robin grant order, wrap flags).
module tb_t64_seq;
  import t64_seq_pkg::*;

  localparam int W  = 8;
  localparam int N  = 8;
  localparam int IW = 3;

  logic          c = 1'b0;
  logic          rn = 1'b1;
  logic [N-1:0]  inc = '0;
  logic          cmd_go = 1'b0;
  logic          cmd_op = 1'b0;
  logic [IW-1:0] cmd_idx = '0;
  logic          busy, rd_vld, lost, mem_ce, mem_r, mem_d, mem_q;
  logic [W-1:0]  rd_data;
  logic [5:0]    mem_s;
  state_e        dbg_state;
`ifdef T64_SEQ_OVF_EN
  logic [N-1:0]  ovf;
`endif

  t64_seq #(.W(W), .N(N), .IW(IW)) dut (
    .c(c), .rn(rn), .inc(inc), .cmd_go(cmd_go), .cmd_op(cmd_op), .cmd_idx(cmd_idx),
    .busy(busy), .rd_vld(rd_vld), .rd_data(rd_data), .lost(lost),
    .mem_s(mem_s), .mem_ce(mem_ce), .mem_r(mem_r), .mem_d(mem_d), .mem_q(mem_q),
`ifdef T64_SEQ_OVF_EN
    .ovf(ovf),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 c = ~c;

  // ---------------- store model ----------------
  logic [63:0]   mem = '0;
  logic          pre_go = 1'b0;
  logic [IW-1:0] pre_idx = '0;
  logic [W-1:0]  pre_val = '0;

  assign mem_q = mem[mem_s];

  always @(posedge c) begin
    if (pre_go) mem[int'(pre_idx)*W +: W] <= pre_val;
    else if (mem_r) mem[mem_s] <= 1'b0;
    else if (mem_ce) mem[mem_s] <= mem_d;
  end

  // ---------------- monitors ----------------
  int ce_cnt = 0, r_cnt = 0, both_cnt = 0, gnt_n = 0;
  logic [IW-1:0] gnt_log [1024];

  always @(negedge c) begin
    if (mem_ce) ce_cnt <= ce_cnt + 1;
    if (mem_r) r_cnt <= r_cnt + 1;
    if (mem_ce && mem_r) both_cnt <= both_cnt + 1;
    if (mem_ce && (int'(mem_s) % W == 0) && gnt_n < 1024) begin
      gnt_log[gnt_n] <= IW'(int'(mem_s) / W);
      gnt_n <= gnt_n + 1;
    end
  end

  // ---------------- reference model and scoreboard ----------------
  logic [W-1:0] exp_cnt [N];
  logic [N-1:0] exp_ovf = '0;
  int           last_gnt = N - 1;
  logic [W-1:0] exp_q [$];
  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int inc_cycles(input logic [W-1:0] v);
    int k = 0;
    while (k < W && v[k]) k++;
    return (k == W) ? W : k + 1;
  endfunction

  task automatic model_inc(input int i);
    if (exp_cnt[i] == {W{1'b1}}) exp_ovf[i] = 1'b1;
    exp_cnt[i] = exp_cnt[i] + 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic settle();
    int quiet = 0;
    for (int t = 0; t < 600 && quiet < 3; t++) begin
      tick();
      if (!busy) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) check("settle_timeout", 0, 1);
  endtask

  task automatic apply_reset();
    tick();
    rn = 1'b0;
    tick();
    tick();
    #2 rn = 1'b1;
    tick();
    exp_ovf = '0;
    last_gnt = N - 1;
  endtask

  task automatic preload(input int i, input logic [W-1:0] v);
    pre_idx = IW'(i);
    pre_val = v;
    pre_go = 1'b1;
    tick();
    pre_go = 1'b0;
    exp_cnt[i] = v;
  endtask

  task automatic pulse_inc(input logic [N-1:0] v);
    inc = v;
    tick();
    inc = '0;
  endtask

  // Pulse a set of increments together from idle, then verify grant order.
  task automatic inc_and_check(input logic [N-1:0] v, input string tag);
    int base, k, start;
    base = gnt_n;
    start = last_gnt;
    k = 0;
    pulse_inc(v);
    settle();
    check({tag, "_ngnt"}, 64'(gnt_n - base), 64'($countones(v)));
    for (int j = 1; j <= N; j++) begin
      int idx;
      idx = (start + j) % N;
      if (v[idx]) begin
        if (base + k < gnt_n) check({tag, "_gnt_order"}, 64'(gnt_log[base+k]), 64'(idx));
        model_inc(idx);
        last_gnt = idx;
        k++;
      end
    end
  endtask

  task automatic check_read(input int i, input string tag);
    int lat;
    exp_q.push_back(exp_cnt[i]);
    cmd_idx = IW'(i);
    cmd_op = OP_RD;
    cmd_go = 1'b1;
    tick();
    cmd_go = 1'b0;
    lat = -1;
    for (int n = 1; n < 40; n++) begin
      if (rd_vld) begin
        lat = n;
        break;
      end
      tick();
    end
    check({tag, "_rd_lat"}, 64'(lat), 64'(W + 1));
    check({tag, "_rd_data"}, 64'(rd_data), 64'(exp_q.pop_front()));
  endtask

  task automatic do_clear(input int i);
    cmd_idx = IW'(i);
    cmd_op = OP_CLR;
    cmd_go = 1'b1;
    tick();
    cmd_go = 1'b0;
    settle();
    exp_cnt[i] = '0;
    exp_ovf[i] = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base, rbase;
    logic [63:0] snap;
    for (int i = 0; i < N; i++) exp_cnt[i] = '0;

    #1 rn = 1'b0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 0);
    check("rst_rd_vld", 64'(rd_vld), 0);
    check("rst_lost", 64'(lost), 0);
    check("rst_mem_ctl", {61'd0, mem_ce, mem_r, mem_d}, 0);
    check("rst_rd_data", 64'(rd_data), 0);
    check("rst_mem_s", 64'(mem_s), 0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    #2 rn = 1'b1;
    tick();

    // 1: single increment then read
    base = ce_cnt;
    inc_and_check(8'h08, "t1");
    check("t1_inc_cycles", 64'(ce_cnt - base), 1);
    check_read(3, "t1");

    // 2: ripple lengths and wrap
    preload(0, 8'h0F);
    base = ce_cnt;
    inc_and_check(8'h01, "t2a");
    check("t2a_inc_cycles", 64'(ce_cnt - base), 64'(inc_cycles(8'h0F)));
    check_read(0, "t2a");
    preload(0, 8'hFF);
    base = ce_cnt;
    inc_and_check(8'h01, "t2b");
    check("t2b_inc_cycles", 64'(ce_cnt - base), 64'(inc_cycles(8'hFF)));
    check_read(0, "t2b");
`ifdef T64_SEQ_OVF_EN
    check("t2b_ovf", 64'(ovf), 64'(exp_ovf));
`endif

    // 3: all counters at once after reset -> grants 0..7
    apply_reset();
    for (int i = 0; i < N; i++) preload(i, 8'h00);
    inc_and_check(8'hFF, "t3");
    for (int i = 0; i < N; i++) check_read(i, "t3");
    check("t3_lost", 64'(lost), 0);

    // 5: clear with an increment pulsed mid-clear
    preload(3, 8'hA3);
    preload(4, 8'h55);
    preload(5, 8'h3C);
    rbase = r_cnt;
    base = gnt_n;
    cmd_idx = 3'd4;
    cmd_op = OP_CLR;
    cmd_go = 1'b1;
    tick();
    cmd_go = 1'b0;
    tick();
    tick();
    tick();
    pulse_inc(8'h10);
    settle();
    exp_cnt[4] = 8'h01;
    exp_ovf[4] = 1'b0;
    last_gnt = 4;
    check("t5_clr_cycles", 64'(r_cnt - rbase), 64'(W));
    check("t5_ngnt", 64'(gnt_n - base), 1);
    check_read(4, "t5_c4");
    check_read(3, "t5_c3");
    check_read(5, "t5_c5");

    // random: grouped increments, reads and clears against the model
    preload(7, 8'hFE);
    for (int it = 0; it < 16; it++) begin
      logic [N-1:0] v;
      v = N'($urandom_range(1, 255));
      inc_and_check(v, "rnd");
      check_read($urandom_range(0, N - 1), "rnd");
      if ($urandom_range(0, 3) == 0) do_clear($urandom_range(0, N - 1));
    end
    for (int i = 0; i < N; i++) check_read(i, "rnd_all");
    check("rnd_lost", 64'(lost), 0);
`ifdef T64_SEQ_OVF_EN
    check("rnd_ovf", 64'(ovf), 64'(exp_ovf));
`endif

    // 4: held increment on counter 2 around the end of counter 5's long ripple
    preload(5, 8'h7F);
    preload(2, 8'h10);
    pulse_inc(8'h20);
    begin
      bit seen = 1'b0;
      for (int t = 0; t < 20; t++) begin
        if (mem_ce && mem_s == 6'd47) begin
          seen = 1'b1;
          break;
        end
        tick();
      end
      check("t4_ripple_seen", 64'(seen), 1);
    end
    inc = 8'h04;
    tick();
    tick();
    tick();
    inc = '0;
    settle();
    exp_cnt[5] = 8'h80;
    exp_cnt[2] = 8'h12;
    last_gnt = 2;
    check("t4_lost", 64'(lost), 1);
    check_read(2, "t4_c2");
    check_read(5, "t4_c5");

    // 6: asynchronous reset in the middle of a read
    preload(6, 8'hA5);
    snap = mem;
    cmd_idx = 3'd6;
    cmd_op = OP_RD;
    cmd_go = 1'b1;
    tick();
    cmd_go = 1'b0;
    tick();
    tick();
    tick();
    check("t6_busy_before", 64'(busy), 1);
    #2 rn = 1'b0;
    #1;
    check("t6_busy", 64'(busy), 0);
    check("t6_rd_vld", 64'(rd_vld), 0);
    check("t6_mem_ce", 64'(mem_ce), 0);
    check("t6_state", 64'(dbg_state), 64'(ST_IDLE));
    check("t6_lost", 64'(lost), 0);
    tick();
    tick();
    check("t6_store", mem, snap);
    #2 rn = 1'b1;
    tick();
    exp_ovf = '0;
    last_gnt = N - 1;
    check_read(6, "t6");
`ifdef T64_SEQ_OVF_EN
    check("t6_ovf", 64'(ovf), 0);
`endif

    check("ce_r_exclusive", 64'(both_cnt), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
